dcache_mem_ctrl: RTL and testbench
==================================

Name: dcache_mem_ctrl

Overview:
- Responder end of the cache-side memory protocol: services the dcache (dREN/dWEN/daddr/dstore -> dwait/dload) and the icache (iREN/iaddr -> iwait/iload) over a single RAM port.
- Registered arbiter with dcache priority.
- Holds the RAM for the dcache between the two words of a block so an icache fetch cannot split a writeback or fill.
- Sits between the cache pair and the RAM model / system bus.

Parameters:
LOCK_CYCLES, 4, idle cycles the dcache keeps the grant after completing an even word (daddr[2]=0) before the grant is released
TIMEOUT, 256, cycles without RAM completion before mem_err is raised (only with MEM_TIMEOUT_EN)

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  asynchronous active-low reset
dREN  in  1  dcache read request
dWEN  in  1  dcache write request
daddr  in  32  dcache word address
dstore  in  32  dcache write data
dwait  out  1  low only in the cycle a dcache word completes
dload  out  32  dcache read data, valid when dwait=0
iREN  in  1  icache read request
iaddr  in  32  icache word address
iwait  out  1  low only in the cycle an icache word completes
iload  out  32  icache read data, valid when iwait=0
ramREN  out  1  RAM read strobe
ramWEN  out  1  RAM write strobe
ramaddr  out  32  RAM address
ramstore  out  32  RAM write data
ramload  in  32  RAM read data
ramstate  in  2  00 FREE, 01 BUSY, 10 ACCESS (word done this cycle), 11 ERROR
mem_err  out  1  sticky timeout flag (0 without MEM_TIMEOUT_EN)

Behaviour:
- Reset (async, nRST=0): state IDLE, lock counter 0, dwait=1, iwait=1, dload=0, iload=0, ramREN=ramWEN=0, ramaddr=0, ramstore=0, mem_err=0. A reset mid-transaction drops all RAM strobes immediately.
- States: IDLE, DSVC, ISVC, DLOCK. Grant is registered, so the first RAM strobe appears one cycle after the request.
- IDLE:
  - dREN|dWEN -> DSVC (dcache wins a simultaneous request).
  - else iREN -> ISVC.
  - else stay.
  - No RAM strobes.
- DSVC:
  - ramaddr=daddr, ramstore=dstore.
  - dWEN=1 -> ramWEN=1, ramREN=0. dWEN has priority if dREN and dWEN are both high.
  - else ramREN=1.
  - While ramstate!=ACCESS: dwait=1.
  - On ramstate=ACCESS: dwait=0 for that cycle and dload=ramload (0 for writes). Next state: DLOCK if daddr[2]=0, else IDLE.
  - If dREN and dWEN both drop before ACCESS: abort, no strobes that cycle, -> IDLE.
- ISVC:
  - ramREN=1, ramaddr=iaddr.
  - On ACCESS: iwait=0, iload=ramload, -> IDLE.
  - iREN drop before ACCESS -> IDLE.
  - dcache requests are not serviced until ISVC completes or aborts; no preemption.
- DLOCK:
  - Lock counter cleared on entry.
  - dREN|dWEN -> DSVC.
  - else counter increments; at LOCK_CYCLES-1 -> IDLE.
  - iREN is ignored while in DLOCK (iwait=1).
- ramstate ERROR or BUSY: not a completion; wait stays high.
- dwait and iwait are 1 in every cycle other than their own completion cycle.
- dload and iload are 0 outside their completion cycle.
- Exactly one completion per ACCESS cycle; the non-granted side never sees its wait drop.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - A 16-bit counter runs in DSVC/ISVC and clears on state change or ACCESS.
  - Reaching TIMEOUT sets mem_err=1, sticky until nRST.
  - Servicing continues; no abort.
- Undefined: no counter, mem_err tied 0.

Test Plan:
- dREN=1, daddr=0x40, RAM ACCESS after 2 BUSY cycles with ramload=0xDEADBEEF -> ramREN first high 1 cycle after the request; dwait=0 and dload=0xDEADBEEF in exactly one cycle; state then DLOCK.
- Block writeback: dWEN to 0x80 (data 0x11), then 0x84 (0x22), iREN held high throughout -> both RAM writes occur back-to-back with no icache access between them; iREN is serviced after 0x84 completes.
- dREN and iREN asserted in the same cycle from IDLE -> DSVC granted first; iwait stays 1 until the dcache word completes, the lock expires (LOCK_CYCLES=4 idle cycles), and the icache access completes.
- Even-word dcache access, then no request -> grant returns to IDLE after 4 cycles; an iREN issued in cycle 2 of DLOCK is serviced only after release.
- dREN dropped while ramstate=BUSY -> ramREN deasserts the next cycle, state IDLE, dwait never drops; nRST pulse mid-ISVC -> all outputs at reset values immediately.
- With MEM_TIMEOUT_EN and TIMEOUT=8: ramstate held BUSY for 10 cycles during DSVC -> mem_err rises after cycle 8 and stays 1 after a later ACCESS; without the macro, mem_err stays 0.

Source files
------------

// File: rtl/dcache_mem_ctrl_if.sv
// dcache_mem_ctrl_if: cache-side and RAM-side signals of dcache_mem_ctrl.
// slave is the controller view, master is the caches/RAM view.
interface dcache_mem_ctrl_if;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        mem_err;

  modport slave (
    input  dREN, dWEN, daddr, dstore,
    output dwait, dload,
    input  iREN, iaddr,
    output iwait, iload,
    output ramREN, ramWEN, ramaddr, ramstore,
    input  ramload, ramstate,
    output mem_err
  );

  modport master (
    output dREN, dWEN, daddr, dstore,
    input  dwait, dload,
    output iREN, iaddr,
    input  iwait, iload,
    input  ramREN, ramWEN, ramaddr, ramstore,
    output ramload, ramstate,
    input  mem_err
  );
endinterface

// File: rtl/dcache_mem_ctrl.sv
// dcache_mem_ctrl: dcache-first arbiter of both caches onto one RAM port.
// Define MEM_TIMEOUT_EN for a sticky mem_err on stalled RAM accesses.
module dcache_mem_ctrl #(
  parameter int LOCK_CYCLES = 4,
  parameter int TIMEOUT     = 256
) (
  input logic CLK,
  input logic nRST,
  dcache_mem_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    DSVC,
    ISVC,
    DLOCK
  } state_t;

  localparam int LW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [1:0] ACCESS = 2'b10;

  state_t state;
  state_t next;
  logic [LW-1:0] lcnt;
  logic [LW-1:0] lcnt_n;
  logic dreq;
  logic done;

  assign dreq = bus.dREN | bus.dWEN;
  assign done = (bus.ramstate == ACCESS);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      lcnt  <= '0;
    end else begin
      state <= next;
      lcnt  <= lcnt_n;
    end
  end

  always_comb begin
    next         = state;
    lcnt_n       = lcnt;
    bus.dwait    = 1'b1;
    bus.iwait    = 1'b1;
    bus.dload    = '0;
    bus.iload    = '0;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    unique case (state)
      IDLE: begin
        if (dreq)
          next = DSVC;
        else if (bus.iREN)
          next = ISVC;
      end
      DSVC: begin
        if (!dreq) begin
          next = IDLE;
        end else begin
          bus.ramaddr  = bus.daddr;
          bus.ramstore = bus.dstore;
          bus.ramWEN   = bus.dWEN;
          bus.ramREN   = !bus.dWEN;
          if (done) begin
            bus.dwait = 1'b0;
            bus.dload = bus.dWEN ? '0 : bus.ramload;
            // even word: keep the RAM for the odd half of the block
            next      = bus.daddr[2] ? IDLE : DLOCK;
            lcnt_n    = '0;
          end
        end
      end
      ISVC: begin
        if (!bus.iREN) begin
          next = IDLE;
        end else begin
          bus.ramREN  = 1'b1;
          bus.ramaddr = bus.iaddr;
          if (done) begin
            bus.iwait = 1'b0;
            bus.iload = bus.ramload;
            next      = IDLE;
          end
        end
      end
      DLOCK: begin
        if (dreq)
          next = DSVC;
        else if (lcnt == LW'(LOCK_CYCLES - 1))
          next = IDLE;
        else
          lcnt_n = lcnt + 1'b1;
      end
      default: next = IDLE;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  logic [15:0] tcnt;
  logic        err;
  logic        svc;

  assign svc = (state == DSVC) || (state == ISVC);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      tcnt <= '0;
      err  <= 1'b0;
    end else if (svc && (next == state)) begin
      if (tcnt != 16'hFFFF)
        tcnt <= tcnt + 16'd1;
      if ((tcnt + 16'd1) == 16'(TIMEOUT))
        err <= 1'b1;
    end else begin
      tcnt <= '0;
    end
  end

  assign bus.mem_err = err;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign bus.mem_err = 1'b0;
`endif

endmodule

// File: tb/tb_dcache_mem_ctrl.sv
// tb_dcache_mem_ctrl: directed scenarios plus random traffic checked
// every cycle against a grant/hold model of the arbiter.
module tb_dcache_mem_ctrl;

  localparam int LOCK = 4;
  localparam int TO   = 8;
  localparam logic [1:0] FREE = 2'b00;
  localparam logic [1:0] BUSY = 2'b01;
  localparam logic [1:0] ACC  = 2'b10;
  localparam logic [1:0] ERR  = 2'b11;

  logic CLK;
  logic nRST;
  int tests;
  int fails;

  dcache_mem_ctrl_if bus();

  dcache_mem_ctrl #(
    .LOCK_CYCLES(LOCK),
    .TIMEOUT(TO)
  ) dut (
    .CLK(CLK),
    .nRST(nRST),
    .bus(bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  // model: who holds the RAM and how many idle hold cycles remain
  bit m_dsvc;
  bit m_isvc;
  int m_hold;
  int m_tcnt;
  bit m_err;
  logic e_dwait, e_iwait, e_ren, e_wen, e_err;
  logic [31:0] e_dload, e_iload, e_addr, e_store;
  logic dreq, acc, cont;

  always @(negedge CLK) begin
    e_dwait = 1'b1;
    e_iwait = 1'b1;
    e_dload = '0;
    e_iload = '0;
    e_ren   = 1'b0;
    e_wen   = 1'b0;
    e_addr  = '0;
    e_store = '0;
    cont    = 1'b0;
    if (!nRST) begin
      m_dsvc = 0;
      m_isvc = 0;
      m_hold = 0;
      m_tcnt = 0;
      m_err  = 0;
    end
    e_err = m_err;
    if (nRST) begin
      dreq = bus.dREN | bus.dWEN;
      acc  = (bus.ramstate == ACC);
      if (m_dsvc) begin
        if (!dreq) begin
          m_dsvc = 0;
        end else begin
          e_addr  = bus.daddr;
          e_store = bus.dstore;
          e_wen   = bus.dWEN;
          e_ren   = !bus.dWEN;
          if (acc) begin
            e_dwait = 1'b0;
            e_dload = bus.dWEN ? 32'h0 : bus.ramload;
            m_dsvc  = 0;
            m_hold  = bus.daddr[2] ? 0 : LOCK;
          end else begin
            cont = 1'b1;
          end
        end
      end else if (m_isvc) begin
        if (!bus.iREN) begin
          m_isvc = 0;
        end else begin
          e_addr = bus.iaddr;
          e_ren  = 1'b1;
          if (acc) begin
            e_iwait = 1'b0;
            e_iload = bus.ramload;
            m_isvc  = 0;
          end else begin
            cont = 1'b1;
          end
        end
      end else if (m_hold > 0) begin
        if (dreq) begin
          m_dsvc = 1;
          m_hold = 0;
        end else begin
          m_hold--;
        end
      end else if (dreq) begin
        m_dsvc = 1;
      end else if (bus.iREN) begin
        m_isvc = 1;
      end
`ifdef MEM_TIMEOUT_EN
      if (cont) begin
        m_tcnt++;
        if (m_tcnt == TO)
          m_err = 1;
      end else begin
        m_tcnt = 0;
      end
`endif
    end
    chk("m_dwait", 32'(bus.dwait), 32'(e_dwait));
    chk("m_iwait", 32'(bus.iwait), 32'(e_iwait));
    chk("m_dload", bus.dload, e_dload);
    chk("m_iload", bus.iload, e_iload);
    chk("m_ramREN", 32'(bus.ramREN), 32'(e_ren));
    chk("m_ramWEN", 32'(bus.ramWEN), 32'(e_wen));
    chk("m_ramaddr", bus.ramaddr, e_addr);
    chk("m_ramstore", bus.ramstore, e_store);
    chk("m_mem_err", 32'(bus.mem_err), 32'(e_err));
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0;
    fails = 0;
    nRST = 1'b0;
    bus.dREN = 0;
    bus.dWEN = 0;
    bus.daddr = '0;
    bus.dstore = '0;
    bus.iREN = 0;
    bus.iaddr = '0;
    bus.ramload = '0;
    bus.ramstate = FREE;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_dwait", 32'(bus.dwait), 1);
    chk("rst_iwait", 32'(bus.iwait), 1);
    chk("rst_ramREN", 32'(bus.ramREN), 0);
    chk("rst_ramaddr", bus.ramaddr, 0);
    chk("rst_mem_err", 32'(bus.mem_err), 0);
    nRST = 1'b1;

    // read 0x40 after two BUSY cycles, then lock with late iREN
    cyc();
    bus.dREN = 1;
    bus.daddr = 32'h40;
    bus.ramstate = BUSY;
    #1;
    chk("t1_c0_ramREN", 32'(bus.ramREN), 0);
    cyc(); #1;
    chk("t1_c1_ramREN", 32'(bus.ramREN), 1);
    chk("t1_c1_addr", bus.ramaddr, 32'h40);
    chk("t1_c1_dwait", 32'(bus.dwait), 1);
    cyc(); #1;
    chk("t1_c2_dwait", 32'(bus.dwait), 1);
    cyc();
    bus.ramstate = ACC;
    bus.ramload = 32'hDEADBEEF;
    #1;
    chk("t1_done_dwait", 32'(bus.dwait), 0);
    chk("t1_done_dload", bus.dload, 32'hDEADBEEF);
    cyc();
    bus.dREN = 0;
    bus.ramstate = FREE;
    #1;
    chk("t1_after_dwait", 32'(bus.dwait), 1);
    chk("t1_after_dload", bus.dload, 0);
    cyc();
    bus.iREN = 1;
    bus.iaddr = 32'h400;
    #1;
    chk("t4_lock_ramREN", 32'(bus.ramREN), 0);
    for (int k = 0; k < 3; k++) begin
      cyc(); #1;
      chk("t4_held_ramREN", 32'(bus.ramREN), 0);
      chk("t4_held_iwait", 32'(bus.iwait), 1);
    end
    cyc();
    bus.ramstate = ACC;
    bus.ramload = 32'h1234;
    #1;
    chk("t4_i_ramREN", 32'(bus.ramREN), 1);
    chk("t4_i_addr", bus.ramaddr, 32'h400);
    chk("t4_i_iwait", 32'(bus.iwait), 0);
    chk("t4_i_iload", bus.iload, 32'h1234);
    cyc();
    bus.iREN = 0;
    bus.ramstate = FREE;

    // block writeback 0x80/0x84 with iREN pending throughout
    bus.dWEN = 1;
    bus.daddr = 32'h80;
    bus.dstore = 32'h11;
    bus.iREN = 1;
    bus.iaddr = 32'h500;
    bus.ramstate = ACC;
    bus.ramload = 32'h77;
    #1;
    chk("t2_c0_ramWEN", 32'(bus.ramWEN), 0);
    cyc(); #1;
    chk("t2_w0_ramWEN", 32'(bus.ramWEN), 1);
    chk("t2_w0_ramREN", 32'(bus.ramREN), 0);
    chk("t2_w0_addr", bus.ramaddr, 32'h80);
    chk("t2_w0_store", bus.ramstore, 32'h11);
    chk("t2_w0_dwait", 32'(bus.dwait), 0);
    chk("t2_w0_dload", bus.dload, 0);
    cyc();
    bus.daddr = 32'h84;
    bus.dstore = 32'h22;
    #1;
    chk("t2_gap_ramREN", 32'(bus.ramREN), 0);
    chk("t2_gap_iwait", 32'(bus.iwait), 1);
    cyc(); #1;
    chk("t2_w1_ramWEN", 32'(bus.ramWEN), 1);
    chk("t2_w1_addr", bus.ramaddr, 32'h84);
    chk("t2_w1_store", bus.ramstore, 32'h22);
    chk("t2_w1_iwait", 32'(bus.iwait), 1);
    cyc();
    bus.dWEN = 0;
    #1;
    chk("t2_idle_ramREN", 32'(bus.ramREN), 0);
    cyc(); #1;
    chk("t2_i_addr", bus.ramaddr, 32'h500);
    chk("t2_i_iwait", 32'(bus.iwait), 0);
    chk("t2_i_iload", bus.iload, 32'h77);
    cyc();
    bus.iREN = 0;
    bus.ramstate = FREE;

    // simultaneous dREN/iREN: dcache, 4 lock cycles, idle, icache
    bus.dREN = 1;
    bus.daddr = 32'h10;
    bus.iREN = 1;
    bus.iaddr = 32'h600;
    bus.ramstate = ACC;
    bus.ramload = 32'hA5;
    #1;
    chk("t3_c0_ramREN", 32'(bus.ramREN), 0);
    cyc(); #1;
    chk("t3_d_dwait", 32'(bus.dwait), 0);
    chk("t3_d_dload", bus.dload, 32'hA5);
    chk("t3_d_iwait", 32'(bus.iwait), 1);
    cyc();
    bus.dREN = 0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0)
        cyc();
      #1;
      chk("t3_wait_iwait", 32'(bus.iwait), 1);
      chk("t3_wait_ramREN", 32'(bus.ramREN), 0);
    end
    cyc(); #1;
    chk("t3_i_iwait", 32'(bus.iwait), 0);
    chk("t3_i_addr", bus.ramaddr, 32'h600);
    cyc();
    bus.iREN = 0;
    bus.ramstate = FREE;

    // abort a busy dcache read
    bus.dREN = 1;
    bus.daddr = 32'h44;
    bus.ramstate = BUSY;
    cyc(); #1;
    chk("t5_busy_ramREN", 32'(bus.ramREN), 1);
    cyc();
    bus.dREN = 0;
    #1;
    chk("t5_drop_ramREN", 32'(bus.ramREN), 0);
    chk("t5_drop_dwait", 32'(bus.dwait), 1);
    cyc(); #1;
    chk("t5_idle_ramREN", 32'(bus.ramREN), 0);

    // reset in the middle of an icache access
    bus.iREN = 1;
    bus.iaddr = 32'h700;
    cyc(); #1;
    chk("t5_isvc_ramREN", 32'(bus.ramREN), 1);
    chk("t5_isvc_addr", bus.ramaddr, 32'h700);
    nRST = 1'b0;
    #1;
    chk("t5_rst_ramREN", 32'(bus.ramREN), 0);
    chk("t5_rst_addr", bus.ramaddr, 0);
    chk("t5_rst_iwait", 32'(bus.iwait), 1);
    bus.iREN = 0;
    cyc();
    nRST = 1'b1;
    cyc();

`ifdef MEM_TIMEOUT_EN
    bus.dREN = 1;
    bus.daddr = 32'h48;
    bus.ramstate = BUSY;
    repeat (8) cyc();
    #1;
    chk("t6_before_err", 32'(bus.mem_err), 0);
    cyc(); #1;
    chk("t6_err_set", 32'(bus.mem_err), 1);
    cyc();
    cyc();
    bus.ramstate = ACC;
    #1;
    chk("t6_done_dwait", 32'(bus.dwait), 0);
    cyc();
    bus.dREN = 0;
    bus.ramstate = FREE;
    #1;
    chk("t6_err_sticky", 32'(bus.mem_err), 1);
`else
    bus.dREN = 1;
    bus.daddr = 32'h48;
    bus.ramstate = BUSY;
    repeat (12) cyc();
    #1;
    chk("t6_no_err", 32'(bus.mem_err), 0);
    bus.dREN = 0;
    bus.ramstate = FREE;
`endif

    // random traffic, checked by the per-cycle model
    for (int n = 0; n < 3000; n++) begin
      int r;
      cyc();
      if ($urandom_range(0, 4) == 0) begin
        bus.dREN = 1'($urandom_range(0, 1));
        bus.dWEN = ($urandom_range(0, 2) == 0);
        bus.daddr = $urandom & 32'h0000_FFFC;
        bus.dstore = $urandom;
      end
      if ($urandom_range(0, 4) == 0) begin
        bus.iREN = 1'($urandom_range(0, 1));
        bus.iaddr = $urandom & 32'h0000_FFFC;
      end
      r = $urandom_range(0, 9);
      bus.ramstate = (r < 1) ? FREE : (r < 5) ? BUSY : (r < 9) ? ACC : ERR;
      bus.ramload = $urandom;
    end
    cyc();
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
